exec_sequencer: RTL and testbench
=================================

Name: exec_sequencer

Overview:
Multi-cycle execution controller for the core. It accepts a fetched instruction and drives the decoder's cycle_counter_i. It gates register-file writes, handshakes with the LSU, selects the next PC and raises traps. Sits between fetch, decoder, LSU and CSR unit; the decoder and ALU stay purely combinational.

Parameters:
LSU_TIMEOUT, 16, cycles lsu_req_o may stay unanswered before a fault (only used with SEQ_LSU_TIMEOUT_EN)

Ports:
clk  in  1  core clock
rst  in  1  synchronous active-high reset
instr_valid_i  in  1  fetch holds a valid instruction on decoder input
instr_ack_o  out  1  one-cycle retire pulse; fetch advances next cycle
cycle_counter_o  out  1  to decoder cycle_counter_i
jump_inst_i  in  1  decoder jump_inst_o
branch_inst_i  in  1  decoder branch_inst_o
lsu_r_en_i  in  1  decoder lsu_r_en_o
lsu_w_en_i  in  1  decoder lsu_w_en_o
rf_we_i  in  1  decoder rf_we_o
ecall_i  in  1  decoder ecall_inst_o
ebreak_i  in  1  decoder ebreak_inst_o
mret_i  in  1  decoder mret_inst_o
illegal_i  in  1  decoder illegal_inst_o
branch_cond_i  in  1  ALU result bit 0 (compare outcome)
lsu_done_i  in  1  LSU completes the pending access
lsu_req_o  out  1  LSU access request, level, held until done
rf_we_o  out  1  gated register-file write enable
pc_we_o  out  1  PC register load
pc_sel_o  out  2  0 PC+inc, 1 ALU result, 2 trap vector, 3 mepc
irq_i  in  1  pending, enabled machine interrupt (level)
trap_o  out  1  one-cycle trap pulse to CSR unit
trap_cause_o  out  4  mcause code, valid with trap_o
trap_irq_o  out  1  trap is an interrupt, valid with trap_o

Behaviour:
- FSM states: IDLE, CYC0, CYC1, MEM, TRAP. Registered state; all outputs are combinational from state and inputs.
- Reset: state IDLE, timeout counter 0. Every output is 0 in IDLE. Reset mid-operation abandons the instruction: lsu_req_o drops the cycle after the reset edge, no ack, no PC write.
- IDLE: if instr_valid_i && irq_i, go to TRAP with cause 11 and irq=1. Else if instr_valid_i, go to CYC0. Interrupts are taken only here, never mid-instruction.
- CYC0 (cycle_counter_o=0), priority order:
  1. illegal_i goes to TRAP, cause 2.
  2. ebreak_i goes to TRAP, cause 3.
  3. ecall_i goes to TRAP, cause 11.
  4. mret_i: pc_sel=3, pc_we, ack, go to IDLE.
  5. lsu_r_en_i or lsu_w_en_i: lsu_req_o=1, go to MEM. If lsu_done_i is already 1, complete this cycle as described in MEM.
  6. jump_inst_i: rf_we_o=rf_we_i (link write), go to CYC1.
  7. branch_inst_i: if branch_cond_i, go to CYC1. Else pc_sel=0, pc_we, ack, go to IDLE.
  8. Otherwise: rf_we_o=rf_we_i, pc_sel=0, pc_we, ack, go to IDLE.
- CYC1 (cycle_counter_o=1): pc_sel=1, pc_we, ack, rf_we_o=0, go to IDLE.
- MEM: cycle_counter_o=0 and lsu_req_o=1 until the cycle lsu_done_i=1. In that cycle: rf_we_o=rf_we_i (loads only; stores have rf_we_i=0), pc_sel=0, pc_we, ack, go to IDLE.
- TRAP: trap_o=1 with cause and irq flag held from the entering cycle, pc_sel=2, pc_we, ack=0, go to IDLE. The faulting instruction stays in fetch and is re-presented only after the handler returns.
- rf_we_o is never 1 in IDLE, CYC1 or TRAP. pc_we_o asserts at most once per instruction. ack coincides with the final pc_we, except for traps.
- Latency: ALU/LUI/AUIPC 2 cycles from valid (IDLE+CYC0). Jump or taken branch 3. Load/store 2+N, where N is the cycles waiting for lsu_done_i.

Optional Feature:
SEQ_LSU_TIMEOUT_EN
- Defined: a counter clears on MEM entry and increments each MEM cycle without lsu_done_i. On reaching LSU_TIMEOUT-1 with no done: drop lsu_req_o and go to TRAP with cause 5 (load) or 7 (store), chosen by lsu_r_en_i. lsu_done_i in the same cycle wins over the timeout.
- Undefined: no counter; MEM waits indefinitely.

Test Plan:
- ADDI, instr_valid_i=1 after reset → cycle_counter 0, rf_we_o=1, pc_sel=0, pc_we and ack in the 2nd cycle; back to IDLE.
- JAL → CYC0 rf_we_o=1, pc_we=0; CYC1 cycle_counter=1, pc_sel=1, pc_we, ack, rf_we_o=0.
- BEQ with branch_cond_i=0 → ack in CYC0 with pc_sel=0. Repeat with branch_cond_i=1 → ack in CYC1 with pc_sel=1.
- LW, lsu_done_i after 3 cycles → lsu_req_o high exactly 4 cycles, rf_we_o and ack only in the done cycle. Repeat with reset asserted in the 2nd MEM cycle → lsu_req_o=0 next cycle, no ack.
- illegal_i=1 together with ebreak_i=1 → trap_o pulse, cause 2, pc_sel=2, no ack, no rf_we. irq_i=1 in IDLE with valid → cause 11, trap_irq_o=1.
- With SEQ_LSU_TIMEOUT_EN and LSU_TIMEOUT=4, SW with no done → trap cause 7 after 4 MEM cycles. Done on the 4th MEM cycle → normal ack, no trap.

Source files
------------

// File: rtl/exec_sequencer_if.sv
// Signal bundle between the execution sequencer and fetch, decoder, LSU and CSR unit.
// The sequencer's own FSM state is carried on dbg_state_o for observation only.
interface exec_sequencer_if;
  logic       instr_valid_i;
  logic       instr_ack_o;
  logic       cycle_counter_o;
  logic       jump_inst_i;
  logic       branch_inst_i;
  logic       lsu_r_en_i;
  logic       lsu_w_en_i;
  logic       rf_we_i;
  logic       ecall_i;
  logic       ebreak_i;
  logic       mret_i;
  logic       illegal_i;
  logic       branch_cond_i;
  logic       lsu_done_i;
  logic       lsu_req_o;
  logic       rf_we_o;
  logic       pc_we_o;
  logic [1:0] pc_sel_o;
  logic       irq_i;
  logic       trap_o;
  logic [3:0] trap_cause_o;
  logic       trap_irq_o;
  logic [2:0] dbg_state_o;

  // lsu_req_o is a level request held until the cycle lsu_done_i is seen high;
  // instr_valid_i is held by fetch until the single-cycle instr_ack_o retire pulse.
  modport slave (
    input  instr_valid_i, jump_inst_i, branch_inst_i, lsu_r_en_i, lsu_w_en_i,
           rf_we_i, ecall_i, ebreak_i, mret_i, illegal_i, branch_cond_i,
           lsu_done_i, irq_i,
    output instr_ack_o, cycle_counter_o, lsu_req_o, rf_we_o, pc_we_o, pc_sel_o,
           trap_o, trap_cause_o, trap_irq_o, dbg_state_o
  );

  modport master (
    output instr_valid_i, jump_inst_i, branch_inst_i, lsu_r_en_i, lsu_w_en_i,
           rf_we_i, ecall_i, ebreak_i, mret_i, illegal_i, branch_cond_i,
           lsu_done_i, irq_i,
    input  instr_ack_o, cycle_counter_o, lsu_req_o, rf_we_o, pc_we_o, pc_sel_o,
           trap_o, trap_cause_o, trap_irq_o, dbg_state_o
  );
endinterface

// File: rtl/exec_sequencer.sv
// Multi-cycle execution controller: sequences decoder cycles, LSU handshake, PC load and traps.
// Optional LSU request timeout enabled by defining SEQ_LSU_TIMEOUT_EN.
module exec_sequencer #(
  parameter int LSU_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  exec_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CYC0 = 3'd1,
    S_CYC1 = 3'd2,
    S_MEM  = 3'd3,
    S_TRAP = 3'd4
  } state_e;

  localparam logic [1:0] PC_INC  = 2'd0;
  localparam logic [1:0] PC_ALU  = 2'd1;
  localparam logic [1:0] PC_TRAP = 2'd2;
  localparam logic [1:0] PC_MEPC = 2'd3;

  state_e     state_q, state_d;
  logic [3:0] cause_q, cause_d;
  logic       irq_q, irq_d;
  logic       lsu_timeout;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cause_q <= 4'd0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      irq_q   <= irq_d;
    end
  end

  always_comb begin
    state_d             = state_q;
    cause_d             = cause_q;
    irq_d               = irq_q;
    bus.instr_ack_o     = 1'b0;
    bus.cycle_counter_o = 1'b0;
    bus.lsu_req_o       = 1'b0;
    bus.rf_we_o         = 1'b0;
    bus.pc_we_o         = 1'b0;
    bus.pc_sel_o        = PC_INC;
    bus.trap_o          = 1'b0;
    bus.trap_cause_o    = 4'd0;
    bus.trap_irq_o      = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Interrupts are only taken between instructions.
        if (bus.instr_valid_i) begin
          if (bus.irq_i) begin
            state_d = S_TRAP;
            cause_d = 4'd11;
            irq_d   = 1'b1;
          end else begin
            state_d = S_CYC0;
          end
        end
      end

      S_CYC0: begin
        if (bus.illegal_i) begin
          state_d = S_TRAP;
          cause_d = 4'd2;
          irq_d   = 1'b0;
        end else if (bus.ebreak_i) begin
          state_d = S_TRAP;
          cause_d = 4'd3;
          irq_d   = 1'b0;
        end else if (bus.ecall_i) begin
          state_d = S_TRAP;
          cause_d = 4'd11;
          irq_d   = 1'b0;
        end else if (bus.mret_i) begin
          bus.pc_sel_o    = PC_MEPC;
          bus.pc_we_o     = 1'b1;
          bus.instr_ack_o = 1'b1;
          state_d         = S_IDLE;
        end else if (bus.lsu_r_en_i || bus.lsu_w_en_i) begin
          bus.lsu_req_o = 1'b1;
          if (bus.lsu_done_i) begin
            bus.rf_we_o     = bus.rf_we_i;
            bus.pc_we_o     = 1'b1;
            bus.instr_ack_o = 1'b1;
            state_d         = S_IDLE;
          end else begin
            state_d = S_MEM;
          end
        end else if (bus.jump_inst_i) begin
          bus.rf_we_o = bus.rf_we_i;
          state_d     = S_CYC1;
        end else if (bus.branch_inst_i) begin
          if (bus.branch_cond_i) begin
            state_d = S_CYC1;
          end else begin
            bus.pc_we_o     = 1'b1;
            bus.instr_ack_o = 1'b1;
            state_d         = S_IDLE;
          end
        end else begin
          bus.rf_we_o     = bus.rf_we_i;
          bus.pc_we_o     = 1'b1;
          bus.instr_ack_o = 1'b1;
          state_d         = S_IDLE;
        end
      end

      S_CYC1: begin
        bus.cycle_counter_o = 1'b1;
        bus.pc_sel_o        = PC_ALU;
        bus.pc_we_o         = 1'b1;
        bus.instr_ack_o     = 1'b1;
        state_d             = S_IDLE;
      end

      S_MEM: begin
        // A done in the same cycle as the timeout still completes the access.
        if (bus.lsu_done_i) begin
          bus.lsu_req_o   = 1'b1;
          bus.rf_we_o     = bus.rf_we_i;
          bus.pc_we_o     = 1'b1;
          bus.instr_ack_o = 1'b1;
          state_d         = S_IDLE;
        end else if (lsu_timeout) begin
          state_d = S_TRAP;
          cause_d = bus.lsu_r_en_i ? 4'd5 : 4'd7;
          irq_d   = 1'b0;
        end else begin
          bus.lsu_req_o = 1'b1;
        end
      end

      S_TRAP: begin
        bus.trap_o       = 1'b1;
        bus.trap_cause_o = cause_q;
        bus.trap_irq_o   = irq_q;
        bus.pc_sel_o     = PC_TRAP;
        bus.pc_we_o      = 1'b1;
        state_d          = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

`ifdef SEQ_LSU_TIMEOUT_EN
  localparam int CNT_W = (LSU_TIMEOUT > 2) ? $clog2(LSU_TIMEOUT) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mem_enter;

  assign mem_enter   = (state_q == S_CYC0) && (state_d == S_MEM);
  assign lsu_timeout = (state_q == S_MEM) && !bus.lsu_done_i &&
                       (cnt_q == CNT_W'(LSU_TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (mem_enter) begin
      cnt_d = '0;
    end else if ((state_q == S_MEM) && !bus.lsu_done_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  // Without the timeout the request is held for as long as the LSU needs.
  assign lsu_timeout = (LSU_TIMEOUT < 0);
`endif

  assign bus.dbg_state_o = state_q;

endmodule

// File: tb/tb_exec_sequencer.sv
// Directed bench for exec_sequencer: per-cycle expected output vectors for each instruction class.
// Output vector layout: {cycle_counter, ack, lsu_req, rf_we, pc_we, pc_sel[1:0], trap, cause[3:0], trap_irq}.
module tb_exec_sequencer;

  logic clk;
  logic rst;
  int   checks;
  int   fails;

  exec_sequencer_if bus ();

  exec_sequencer #(.LSU_TIMEOUT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [12:0] obs;
  assign obs = {bus.cycle_counter_o, bus.instr_ack_o, bus.lsu_req_o, bus.rf_we_o,
                bus.pc_we_o, bus.pc_sel_o, bus.trap_o, bus.trap_cause_o, bus.trap_irq_o};

  function automatic logic [12:0] ov(int cc, int ack, int req, int rfwe, int pcwe,
                                     int sel, int trap, int cause, int irq);
    logic [31:0] s;
    logic [31:0] c;
    s = sel;
    c = cause;
    ov = {cc[0], ack[0], req[0], rfwe[0], pcwe[0], s[1:0], trap[0], c[3:0], irq[0]};
  endfunction

  // driver tasks
  task automatic clear_inputs();
    bus.instr_valid_i = 1'b0;
    bus.jump_inst_i   = 1'b0;
    bus.branch_inst_i = 1'b0;
    bus.lsu_r_en_i    = 1'b0;
    bus.lsu_w_en_i    = 1'b0;
    bus.rf_we_i       = 1'b0;
    bus.ecall_i       = 1'b0;
    bus.ebreak_i      = 1'b0;
    bus.mret_i        = 1'b0;
    bus.illegal_i     = 1'b0;
    bus.branch_cond_i = 1'b0;
    bus.lsu_done_i    = 1'b0;
    bus.irq_i         = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_check(string name);
    @(negedge clk);
    checks++;
    if (obs !== 13'd0 || bus.dbg_state_o !== 3'd0) begin
      fails++;
      $display("FAIL %s_idle: got outs=%b state=%0d, want outs=0 state=0", name, obs, bus.dbg_state_o);
    end
    tick();
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    bus.instr_valid_i = 1'b1;
    bus.irq_i = 1'b1;
    tick();
    tick();
    @(negedge clk);
    checks++;
    if (obs !== 13'd0 || bus.dbg_state_o !== 3'd0) begin
      fails++;
      $display("FAIL reset: got outs=%b state=%0d, want outs=0 state=0", obs, bus.dbg_state_o);
    end
    clear_inputs();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_alu();
    logic [12:0] exp_q[$];
    clear_inputs();
    bus.instr_valid_i = 1'b1;
    bus.rf_we_i = 1'b1;
    exp_q = '{ov(0,0,0,0,0,0,0,0,0), ov(0,1,0,1,1,0,0,0,0)};
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      checks++;
      if (obs !== exp_q[i]) begin
        fails++;
        $display("FAIL alu cyc%0d: got %b want %b", i, obs, exp_q[i]);
      end
      tick();
    end
    clear_inputs();
    idle_check("alu");
  endtask

  task automatic test_jump();
    logic [12:0] exp_q[$];
    clear_inputs();
    bus.instr_valid_i = 1'b1;
    bus.jump_inst_i = 1'b1;
    bus.rf_we_i = 1'b1;
    exp_q = '{ov(0,0,0,0,0,0,0,0,0), ov(0,0,0,1,0,0,0,0,0), ov(1,1,0,0,1,1,0,0,0)};
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      checks++;
      if (obs !== exp_q[i]) begin
        fails++;
        $display("FAIL jal cyc%0d: got %b want %b", i, obs, exp_q[i]);
      end
      tick();
    end
    clear_inputs();
    idle_check("jal");
  endtask

  task automatic test_branch(input logic taken);
    logic [12:0] exp_q[$];
    clear_inputs();
    bus.instr_valid_i = 1'b1;
    bus.branch_inst_i = 1'b1;
    bus.branch_cond_i = taken;
    // irq raised mid-instruction must not disturb the branch
    if (taken)
      exp_q = '{ov(0,0,0,0,0,0,0,0,0), ov(0,0,0,0,0,0,0,0,0), ov(1,1,0,0,1,1,0,0,0)};
    else
      exp_q = '{ov(0,0,0,0,0,0,0,0,0), ov(0,1,0,0,1,0,0,0,0)};
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      checks++;
      if (obs !== exp_q[i]) begin
        fails++;
        $display("FAIL beq_taken%0d cyc%0d: got %b want %b", taken, i, obs, exp_q[i]);
      end
      tick();
      if (i == 0) bus.irq_i = 1'b1;
    end
    clear_inputs();
    idle_check("beq");
  endtask

  task automatic test_load();
    logic [12:0] exp_q[$];
    int req_cycles;
    clear_inputs();
    req_cycles = 0;
    bus.instr_valid_i = 1'b1;
    bus.lsu_r_en_i = 1'b1;
    bus.rf_we_i = 1'b1;
    exp_q = '{ov(0,0,0,0,0,0,0,0,0), ov(0,0,1,0,0,0,0,0,0), ov(0,0,1,0,0,0,0,0,0),
              ov(0,0,1,0,0,0,0,0,0), ov(0,1,1,1,1,0,0,0,0)};
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      checks++;
      if (obs !== exp_q[i]) begin
        fails++;
        $display("FAIL lw cyc%0d: got %b want %b", i, obs, exp_q[i]);
      end
      if (bus.lsu_req_o === 1'b1) req_cycles++;
      tick();
      if (i == 3) bus.lsu_done_i = 1'b1;
    end
    clear_inputs();
    checks++;
    if (req_cycles != 4) begin
      fails++;
      $display("FAIL lw_req_len: got %0d want 4", req_cycles);
    end
    idle_check("lw");
  endtask

  task automatic test_load_reset();
    logic [12:0] exp_q[$];
    clear_inputs();
    bus.instr_valid_i = 1'b1;
    bus.lsu_r_en_i = 1'b1;
    bus.rf_we_i = 1'b1;
    exp_q = '{ov(0,0,0,0,0,0,0,0,0), ov(0,0,1,0,0,0,0,0,0), ov(0,0,1,0,0,0,0,0,0),
              ov(0,0,1,0,0,0,0,0,0), ov(0,0,0,0,0,0,0,0,0)};
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      checks++;
      if (obs !== exp_q[i]) begin
        fails++;
        $display("FAIL lw_reset cyc%0d: got %b want %b", i, obs, exp_q[i]);
      end
      tick();
      if (i == 2) rst = 1'b1;
    end
    rst = 1'b0;
    clear_inputs();
    idle_check("lw_reset");
  endtask

  task automatic test_store_fast();
    logic [12:0] exp_q[$];
    clear_inputs();
    bus.instr_valid_i = 1'b1;
    bus.lsu_w_en_i = 1'b1;
    bus.lsu_done_i = 1'b1;
    exp_q = '{ov(0,0,0,0,0,0,0,0,0), ov(0,1,1,0,1,0,0,0,0)};
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      checks++;
      if (obs !== exp_q[i]) begin
        fails++;
        $display("FAIL sw_fast cyc%0d: got %b want %b", i, obs, exp_q[i]);
      end
      tick();
    end
    clear_inputs();
    idle_check("sw_fast");
  endtask

  task automatic test_illegal();
    logic [12:0] exp_q[$];
    clear_inputs();
    bus.instr_valid_i = 1'b1;
    bus.illegal_i = 1'b1;
    bus.ebreak_i = 1'b1;
    bus.rf_we_i = 1'b1;
    exp_q = '{ov(0,0,0,0,0,0,0,0,0), ov(0,0,0,0,0,0,0,0,0), ov(0,0,0,0,1,2,1,2,0)};
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      checks++;
      if (obs !== exp_q[i]) begin
        fails++;
        $display("FAIL illegal cyc%0d: got %b want %b", i, obs, exp_q[i]);
      end
      tick();
    end
    clear_inputs();
    idle_check("illegal");
  endtask

  task automatic test_sys();
    logic [12:0] exp_q[$];
    clear_inputs();
    bus.instr_valid_i = 1'b1;
    bus.ecall_i = 1'b1;
    bus.mret_i = 1'b1;
    // ecall beats mret; then mret alone returns via mepc
    exp_q = '{ov(0,0,0,0,0,0,0,0,0), ov(0,0,0,0,0,0,0,0,0), ov(0,0,0,0,1,2,1,11,0),
              ov(0,0,0,0,0,0,0,0,0), ov(0,1,0,0,1,3,0,0,0)};
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      checks++;
      if (obs !== exp_q[i]) begin
        fails++;
        $display("FAIL sys cyc%0d: got %b want %b", i, obs, exp_q[i]);
      end
      tick();
      if (i == 2) bus.ecall_i = 1'b0;
    end
    clear_inputs();
    idle_check("sys");
  endtask

  task automatic test_irq();
    logic [12:0] exp_q[$];
    clear_inputs();
    bus.instr_valid_i = 1'b1;
    bus.irq_i = 1'b1;
    bus.rf_we_i = 1'b1;
    exp_q = '{ov(0,0,0,0,0,0,0,0,0), ov(0,0,0,0,1,2,1,11,1)};
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      checks++;
      if (obs !== exp_q[i]) begin
        fails++;
        $display("FAIL irq cyc%0d: got %b want %b", i, obs, exp_q[i]);
      end
      tick();
    end
    clear_inputs();
    idle_check("irq");
  endtask

  task automatic test_back_to_back();
    logic [12:0] exp_q[$];
    clear_inputs();
    bus.instr_valid_i = 1'b1;
    bus.rf_we_i = 1'b1;
    exp_q = '{ov(0,0,0,0,0,0,0,0,0), ov(0,1,0,1,1,0,0,0,0),
              ov(0,0,0,0,0,0,0,0,0), ov(0,1,0,1,1,0,0,0,0)};
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      checks++;
      if (obs !== exp_q[i]) begin
        fails++;
        $display("FAIL b2b cyc%0d: got %b want %b", i, obs, exp_q[i]);
      end
      tick();
    end
    clear_inputs();
    idle_check("b2b");
  endtask

`ifdef SEQ_LSU_TIMEOUT_EN
  task automatic test_timeout(input logic done_last);
    logic [12:0] exp_q[$];
    clear_inputs();
    bus.instr_valid_i = 1'b1;
    bus.lsu_w_en_i = 1'b1;
    if (done_last)
      exp_q = '{ov(0,0,0,0,0,0,0,0,0), ov(0,0,1,0,0,0,0,0,0), ov(0,0,1,0,0,0,0,0,0),
                ov(0,0,1,0,0,0,0,0,0), ov(0,0,1,0,0,0,0,0,0), ov(0,1,1,0,1,0,0,0,0),
                ov(0,0,0,0,0,0,0,0,0)};
    else
      exp_q = '{ov(0,0,0,0,0,0,0,0,0), ov(0,0,1,0,0,0,0,0,0), ov(0,0,1,0,0,0,0,0,0),
                ov(0,0,1,0,0,0,0,0,0), ov(0,0,1,0,0,0,0,0,0), ov(0,0,0,0,0,0,0,0,0),
                ov(0,0,0,0,1,2,1,7,0)};
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      checks++;
      if (obs !== exp_q[i]) begin
        fails++;
        $display("FAIL timeout_done%0d cyc%0d: got %b want %b", done_last, i, obs, exp_q[i]);
      end
      tick();
      if (i == 4 && done_last) bus.lsu_done_i = 1'b1;
      if (i == 5) clear_inputs();
    end
    clear_inputs();
    idle_check("timeout");
  endtask
`endif

  initial begin
    checks = 0;
    fails = 0;
    clear_inputs();
    rst = 1'b1;
    test_reset();
    test_alu();
    test_jump();
    test_branch(1'b0);
    test_branch(1'b1);
    test_load();
    test_load_reset();
    test_store_fast();
    test_illegal();
    test_sys();
    test_irq();
    test_back_to_back();
`ifdef SEQ_LSU_TIMEOUT_EN
    test_timeout(1'b0);
    test_timeout(1'b1);
`endif
    $display("[TB] %0d tests run, %0d failed", checks, fails);
    $finish;
  end

endmodule
